// File: rtl/led_fill_sequencer.sv
// rtl/led_fill_sequencer.sv - button-driven thermometer LED bar fill/drain sequencer
module led_fill_sequencer #(
  parameter int WIDTH       = 16,
  parameter int STEP_CYCLES = 4,
  parameter int DEBOUNCE    = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             button,
  input  logic             mode,
  output logic [WIDTH-1:0] led,
  output logic             busy,
  output logic             done,
  output logic             paused
);
  localparam int LW = $clog2(WIDTH + 1);
  localparam int TW = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
  localparam int CW = $clog2(DEBOUNCE + 1);

  localparam logic [TW-1:0] T_LAST = TW'(STEP_CYCLES - 1);
  localparam logic [LW-1:0] L_FULL = LW'(WIDTH);
  localparam logic [CW-1:0] C_MAX  = CW'(DEBOUNCE);
  localparam logic [CW-1:0] C_HIT  = CW'(DEBOUNCE - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FILL,
    S_DRAIN,
    S_PAUSED,
    S_DONE
  } state_t;

  logic          sync1, sync2, db, db_d;
  logic [CW-1:0] db_cnt;
  logic          press;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1  <= 1'b0;
      sync2  <= 1'b0;
      db     <= 1'b0;
      db_d   <= 1'b0;
      db_cnt <= '0;
    end else begin
      sync1 <= button;
      sync2 <= sync1;
      db_d  <= db;
      if (!sync2) begin
        db_cnt <= '0;
        db     <= 1'b0;
      end else begin
        if (db_cnt != C_MAX) db_cnt <= db_cnt + CW'(1);
        // db rises on the same edge the count reaches DEBOUNCE
        if (db_cnt >= C_HIT) db <= 1'b1;
      end
    end
  end

  assign press = db & ~db_d;

  state_t        state, state_nx, ret, ret_nx;
  logic [LW-1:0] level, level_nx;
  logic [TW-1:0] timer, timer_nx;
  logic          step;

  assign step = (timer == T_LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_IDLE;
      ret   <= S_FILL;
      level <= '0;
      timer <= '0;
    end else begin
      state <= state_nx;
      ret   <= ret_nx;
      level <= level_nx;
      timer <= timer_nx;
    end
  end

  always_comb begin
    state_nx = state;
    ret_nx   = ret;
    level_nx = level;
    timer_nx = timer;
    case (state)
      S_IDLE: begin
        level_nx = '0;
        if (press) begin
          state_nx = S_FILL;
          timer_nx = '0;
        end
      end
      S_FILL: begin
        // press beats a coincident step; timer is left untouched so it resumes where it was
        if (press) begin
          state_nx = S_PAUSED;
          ret_nx   = S_FILL;
        end else if (step) begin
          timer_nx = '0;
          level_nx = level + LW'(1);
          if (level_nx == L_FULL) state_nx = mode ? S_DRAIN : S_DONE;
        end else begin
          timer_nx = timer + TW'(1);
        end
      end
      S_DRAIN: begin
        if (press) begin
          state_nx = S_PAUSED;
          ret_nx   = S_DRAIN;
        end else if (step) begin
          timer_nx = '0;
          level_nx = level - LW'(1);
          if (level_nx == '0) state_nx = mode ? S_FILL : S_IDLE;
        end else begin
          timer_nx = timer + TW'(1);
        end
      end
      S_PAUSED: begin
        if (press) state_nx = ret;
      end
      S_DONE: begin
        level_nx = L_FULL;
        if (press) begin
          state_nx = S_IDLE;
          level_nx = '0;
        end
      end
      default: begin
        state_nx = S_IDLE;
        level_nx = '0;
        timer_nx = '0;
      end
    endcase
  end

  // equivalent to the low WIDTH bits of (1<<level)-1, including level==WIDTH
  assign led    = ~({WIDTH{1'b1}} << level);
  assign busy   = (state == S_FILL) || (state == S_DRAIN) || (state == S_PAUSED);
  assign done   = (state == S_DONE);
  assign paused = (state == S_PAUSED);

endmodule

// File: tb/tb_led_fill_sequencer.sv
// tb/tb_led_fill_sequencer.sv - self-checking bench for led_fill_sequencer
module tb_led_fill_sequencer;
  localparam int WIDTH = 16;
  localparam int STEP  = 4;
  localparam int DEB   = 3;

  logic             clk    = 1'b0;
  logic             rst    = 1'b0;
  logic             button = 1'b0;
  logic             mode   = 1'b0;
  logic [WIDTH-1:0] led;
  logic             busy, done, paused;

  int          errors = 0;
  int          checks = 0;
  int unsigned edge_n = 0;
  int unsigned base, e0;

  led_fill_sequencer #(
    .WIDTH(WIDTH),
    .STEP_CYCLES(STEP),
    .DEBOUNCE(DEB)
  ) dut (
    .clk(clk),
    .rst(rst),
    .button(button),
    .mode(mode),
    .led(led),
    .busy(busy),
    .done(done),
    .paused(paused)
  );

  always #5 clk = ~clk;
  always @(posedge clk) edge_n <= edge_n + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // Model: press when the DEB button samples ending three edges back are all high
  // and the window one edge older was not; bar driven by run/pause/done flags.
  bit [31:0] hist    = '0;
  int        m_level = 0;
  int        m_ticks = 0;
  int        m_dir   = 1;
  bit        m_run   = 1'b0;
  bit        m_pause = 1'b0;
  bit        m_done  = 1'b0;

  function automatic bit all_high(input bit [31:0] h, input int lo);
    for (int i = 0; i < DEB; i++) if (!h[lo+i]) return 1'b0;
    return 1'b1;
  endfunction

  function automatic logic [31:0] exp_led(input int lvl);
    logic [63:0] one;
    one = 64'd1;
    return 32'((one << lvl) - 64'd1);
  endfunction

  always @(posedge clk or negedge rst) begin
    bit p;
    if (!rst) begin
      hist    = '0;
      m_level = 0;
      m_ticks = 0;
      m_dir   = 1;
      m_run   = 1'b0;
      m_pause = 1'b0;
      m_done  = 1'b0;
    end else begin
      p = all_high(hist, 2) && !all_high(hist, 3);
      if (m_done) begin
        if (p) begin
          m_done  = 1'b0;
          m_level = 0;
        end
      end else if (m_pause) begin
        if (p) m_pause = 1'b0;
      end else if (m_run) begin
        if (p) m_pause = 1'b1;
        else begin
          m_ticks++;
          if (m_ticks == STEP) begin
            m_ticks = 0;
            m_level += m_dir;
            if (m_level == WIDTH) begin
              if (mode) m_dir = -1;
              else begin
                m_run  = 1'b0;
                m_done = 1'b1;
              end
            end else if (m_level == 0) begin
              if (mode) m_dir = 1;
              else m_run = 1'b0;
            end
          end
        end
      end else if (p) begin
        m_run   = 1'b1;
        m_dir   = 1;
        m_ticks = 0;
      end
      hist = {hist[30:0], button};
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      check("model_led", 32'(led), exp_led(m_level));
      check("model_busy", 32'(busy), 32'(m_run));
      check("model_done", 32'(done), 32'(m_done));
      check("model_paused", 32'(paused), 32'(m_pause));
    end
  end

  task automatic wait_edge(input int unsigned n);
    while (edge_n < n) @(negedge clk);
  endtask

  // button high for samples T-5..T-1 so the FSM acts on the press at edge T
  task automatic schedule_press(input int unsigned t);
    wait_edge(t - 6);
    button = 1'b1;
    wait_edge(t - 1);
    button = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    #200000;
    errors++;
    $display("FAIL watchdog actual=timeout required=finish");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    repeat (3) @(negedge clk);
    check("rst_led", 32'(led), 32'h0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_paused", 32'(paused), 32'd0);
    rst = 1'b1;

    // held button, fill once
    @(negedge clk);
    base   = edge_n;
    button = 1'b1;
    wait_edge(base + 5);
    check("pre_press_busy", 32'(busy), 32'd0);
    wait_edge(base + 6);
    check("press_busy", 32'(busy), 32'd1);
    check("press_led", 32'(led), 32'h0);
    wait_edge(base + 10);
    check("first_step_led", 32'(led), 32'h0001);
    wait_edge(base + 69);
    check("lvl15_led", 32'(led), 32'h7FFF);
    check("lvl15_done", 32'(done), 32'd0);
    wait_edge(base + 70);
    check("full_led", 32'(led), 32'hFFFF);
    check("full_done", 32'(done), 32'd1);
    check("full_busy", 32'(busy), 32'd0);
    button = 1'b0;
    e0 = edge_n + 10;
    schedule_press(e0);
    wait_edge(e0);
    check("done_clear_led", 32'(led), 32'h0);
    check("done_clear_done", 32'(done), 32'd0);

    // short glitches
    @(negedge clk);
    button = 1'b1;
    @(negedge clk);
    button = 1'b0;
    repeat (4) @(negedge clk);
    button = 1'b1;
    repeat (2) @(negedge clk);
    button = 1'b0;
    repeat (10) @(negedge clk);
    check("glitch_busy", 32'(busy), 32'd0);
    check("glitch_led", 32'(led), 32'h0);

    // bounce mode, then reset mid-drain
    mode = 1'b1;
    e0 = edge_n + 8;
    schedule_press(e0);
    wait_edge(e0 + 64);
    check("bounce_full", 32'(led), 32'hFFFF);
    wait_edge(e0 + 68);
    check("bounce_drain1", 32'(led), 32'h7FFF);
    check("bounce_busy", 32'(busy), 32'd1);
    wait_edge(e0 + 124);
    check("bounce_lvl1", 32'(led), 32'h0001);
    wait_edge(e0 + 128);
    check("bounce_empty", 32'(led), 32'h0);
    check("bounce_empty_busy", 32'(busy), 32'd1);
    wait_edge(e0 + 132);
    check("bounce_refill", 32'(led), 32'h0001);
    wait_edge(e0 + 200);
    check("bounce_lvl14", 32'(led), 32'h3FFF);
    #2 rst = 1'b0;
    #1;
    check("async_rst_led", 32'(led), 32'h0);
    check("async_rst_busy", 32'(busy), 32'd0);
    check("async_rst_done", 32'(done), 32'd0);
    check("async_rst_paused", 32'(paused), 32'd0);
    @(negedge clk);
    rst  = 1'b1;
    mode = 1'b0;
    repeat (8) @(negedge clk);
    check("post_rst_idle", 32'(busy), 32'd0);

    // pause at level 5 mid-step
    e0 = edge_n + 8;
    schedule_press(e0);
    schedule_press(e0 + 22);
    wait_edge(e0 + 22);
    check("pause5_paused", 32'(paused), 32'd1);
    check("pause5_led", 32'(led), 32'h001F);
    wait_edge(e0 + 42);
    check("pause5_hold_led", 32'(led), 32'h001F);
    check("pause5_hold_busy", 32'(busy), 32'd1);
    schedule_press(e0 + 50);
    wait_edge(e0 + 50);
    check("resume5_paused", 32'(paused), 32'd0);
    wait_edge(e0 + 52);
    check("resume5_pre_step", 32'(led), 32'h001F);
    wait_edge(e0 + 53);
    check("resume5_step", 32'(led), 32'h003F);

    // press coincident with a step at level 3
    do_reset();
    e0 = edge_n + 8;
    schedule_press(e0);
    schedule_press(e0 + 16);
    wait_edge(e0 + 16);
    check("stepedge_paused", 32'(paused), 32'd1);
    check("stepedge_led", 32'(led), 32'h0007);
    schedule_press(e0 + 30);
    wait_edge(e0 + 30);
    check("stepedge_resume_led", 32'(led), 32'h0007);
    check("stepedge_resume_paused", 32'(paused), 32'd0);
    wait_edge(e0 + 31);
    check("stepedge_first_run", 32'(led), 32'h000F);

    repeat (4) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
